// File: rtl/formula_pkg.sv
// formula_pkg: shared state encoding and mode constants for formula_seq_unit.
`default_nettype none

package formula_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S1_OP  = 3'd1,
    ST_S1_CAP = 3'd2,
    ST_S2_OP  = 3'd3,
    ST_S2_CAP = 3'd4,
    ST_S3_OP  = 3'd5,
    ST_S3_CAP = 3'd6
  } state_t;

  localparam logic [1:0] MODE_ABSDIFF = 2'b00;
  localparam logic [1:0] MODE_ADD     = 2'b01;
  localparam logic [1:0] MODE_SUB     = 2'b10;
  localparam logic [1:0] MODE_DBLMIN  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/addsub_ripple.sv
// addsub_ripple: combinational N-bit ripple add/subtract; o_carry is the raw
// carry out (for subtraction, borrow = ~o_carry).
`default_nettype none

module addsub_ripple #(
  parameter int N = 6
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_res,
  output logic         o_carry
);

  logic [N:0] w_c;

  assign w_c[0] = i_sub;

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic w_bx;
    assign w_bx     = i_b[i] ^ i_sub;
    assign o_res[i] = i_a[i] ^ w_bx ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & w_bx) | (w_c[i] & (i_a[i] ^ w_bx));
  end

  assign o_carry = w_c[N];

endmodule

`default_nettype wire

// File: rtl/formula_seq_unit.sv
// formula_seq_unit: FSM-sequenced four-mode formula unit on one shared adder.
// Optional macro CLAMP_NEG_EN: saturate negative mode-10 results to zero.
`default_nettype none

module formula_seq_unit
  import formula_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W:0]   c_out,
  output logic         neg,
  output logic         busy,
  output logic         done
);

  state_t       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [1:0]   r_mode;
  logic [W:0]   r_i1;
  logic [W:0]   r_i2;
  logic [W:0]   r_c_out;
  logic         r_neg;
  logic         r_busy;
  logic         r_done;

  logic [W:0]   w_max;
  logic [W:0]   w_min;
  logic [W:0]   w_opa;
  logic [W:0]   w_opb;
  logic         w_sub;
  logic [W:0]   w_res;
  logic         w_carry;
  logic         w_borrow;

  assign w_max = (r_a >= r_b) ? {1'b0, r_a} : {1'b0, r_b};
  assign w_min = (r_a >= r_b) ? {1'b0, r_b} : {1'b0, r_a};

  // Operands stay stable across each OP/CAP pair so the capture sees a settled sum.
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_sub = 1'b0;
    case (r_state)
      ST_S1_OP, ST_S1_CAP: begin
        case (r_mode)
          MODE_ABSDIFF: begin w_opa = w_max; w_opb = w_max; end
          MODE_ADD:     begin w_opa = {1'b0, r_a}; w_opb = {1'b0, r_b}; end
          MODE_SUB:     begin w_opa = {1'b0, r_a}; w_opb = {1'b0, r_b}; w_sub = 1'b1; end
          default:      begin w_opa = w_min; w_opb = w_min; end
        endcase
      end
      ST_S2_OP, ST_S2_CAP: begin
        w_opa = {1'b0, r_a};
        w_opb = {1'b0, r_b};
      end
      ST_S3_OP, ST_S3_CAP: begin
        w_opa = r_i1;
        w_opb = r_i2;
        w_sub = 1'b1;
      end
      default: ;
    endcase
  end

  addsub_ripple #(.N(W + 1)) u_addsub (
    .i_a     (w_opa),
    .i_b     (w_opb),
    .i_sub   (w_sub),
    .o_res   (w_res),
    .o_carry (w_carry)
  );

  assign w_borrow = w_sub & ~w_carry;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= '0;
      r_i1    <= '0;
      r_i2    <= '0;
      r_c_out <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_mode  <= mode;
            r_busy  <= 1'b1;
            r_state <= ST_S1_OP;
          end
        end
        ST_S1_OP: r_state <= ST_S1_CAP;
        ST_S1_CAP: begin
          if (r_mode == MODE_ABSDIFF) begin
            r_i1    <= w_res;
            r_state <= ST_S2_OP;
          end else begin
            r_c_out <= w_res;
            r_neg   <= (r_mode == MODE_SUB) ? w_borrow : 1'b0;
`ifdef CLAMP_NEG_EN
            if ((r_mode == MODE_SUB) && w_borrow) r_c_out <= '0;
`endif
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_S2_OP: r_state <= ST_S2_CAP;
        ST_S2_CAP: begin
          r_i2    <= w_res;
          r_state <= ST_S3_OP;
        end
        ST_S3_OP: r_state <= ST_S3_CAP;
        ST_S3_CAP: begin
          r_c_out <= w_res;
          r_neg   <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign c_out = r_c_out;
  assign neg   = r_neg;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_formula_seq_unit.sv
// tb_formula_seq_unit: scoreboard bench with a behavioural formula model.
`default_nettype none

module tb_formula_seq_unit;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W:0]   c_out;
  logic         neg;
  logic         busy;
  logic         done;

  formula_seq_unit #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_out (c_out),
    .neg   (neg),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int n;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: formulas straight from their arithmetic definitions.
  function automatic void model(input int md, input int a, input int b,
                                output int c, output int n, output int lat);
    n   = 0;
    lat = 2;
    case (md)
      0: begin c = (a > b) ? a - b : b - a; lat = 6; end
      1: c = a + b;
      2: begin
        c = (a - b + 64) % 64;
        n = (a < b) ? 1 : 0;
`ifdef CLAMP_NEG_EN
        if (a < b) c = 0;
`endif
      end
      default: c = 2 * ((a < b) ? a : b);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("c_out", int'(c_out), e.c);
        chk("neg", int'(neg), e.n);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic launch(input int md, input int a, input int b, input bit expect_it);
    exp_t e;
    int   lat;
    mode  = 2'(md);
    a_in  = W'(a);
    b_in  = W'(b);
    start = 1'b1;
    if (expect_it) begin
      model(md, a, b, e.c, e.n, lat);
      e.cyc = cyc + 1 + lat;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    mode  = 2'($urandom);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_done < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d dones expected %0d", n_done, target);
      q.delete();
      n_done = target;
    end
  endtask

  task automatic run(input int md, input int a, input int b);
    int t;
    t = n_done + 1;
    launch(md, a, b, 1'b1);
    wait_done(t);
  endtask

  initial begin
    int t;
    rst   = 1'b0;
    start = 1'b1;
    mode  = 2'b01;
    a_in  = 5'd7;
    b_in  = 5'd9;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_c_out", int'(c_out), 0);
    chk("rst_neg", int'(neg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);

    run(0, 9, 3);
    run(0, 3, 9);
    run(0, 31, 31);
    run(1, 31, 31);
    run(3, 20, 7);
    run(2, 3, 9);
    run(2, 9, 3);
    run(2, 0, 31);
    run(3, 5, 5);

    // Second start two cycles into a mode-00 run must be ignored.
    t = n_done + 1;
    launch(0, 17, 30, 1'b1);
    @(negedge clk);
    #1;
    chk("busy_mid_run", int'(busy), 1);
    launch(1, 1, 1, 1'b0);
    wait_done(t);
    repeat (4) @(negedge clk);

    // Abort mid-run: no done, outputs cleared.
    launch(0, 25, 4, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_c_out", int'(c_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    run(1, 1, 2);

    // Randomised traffic, back-to-back where the previous op just completed.
    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/formula_seq_unit.md
Name: formula_seq_unit

Overview:
- Parametrised, multi-mode successor to the 5-bit 2*max(a,b)-(a+b) sequencer.
- Computes one of four formulas on two unsigned W-bit operands using a single shared ripple add/subtract datapath, stepped by an FSM.
- Adds a start/busy/done handshake, widened W+1 result, borrow flag and full output reset.
- Sits between operand registers and the result consumer in the formula-calculation datapath.

Parameters:
W, 5, operand width in bits (>=2); result width is W+1

Ports:
clk    in   1    clock, all state updates on rising edge
rst    in   1    reset, synchronous, active-low
start  in   1    request; sampled only in IDLE
mode   in   2    formula select, latched with operands
a_in   in   W    operand A, unsigned
b_in   in   W    operand B, unsigned
c_out  out  W+1  result, registered, held until next done
neg    out  1    borrow of final subtraction (mode 10 only; else 0)
busy   out  1    high from the cycle after start is accepted through final capture
done   out  1    one-cycle pulse, coincident with new c_out

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; c_out=0, neg=0, busy=0, done=0; internal operand/intermediate registers cleared. Reset overrides everything, including mid-operation; the aborted result is discarded and no done pulse is issued.
- Modes (M=max(a,b), m=min(a,b), arithmetic in W+1 bits):
  - 00: 2M-(a+b), i.e. |a-b|
  - 01: a+b
  - 10: a-b, two's complement, wraps mod 2^(W+1); neg=borrow
  - 11: 2m
- No overflow is possible in modes 00/01/11, since all fit in W+1 bits.
- States: IDLE, S1_OP, S1_CAP, S2_OP, S2_CAP, S3_OP, S3_CAP.
  - IDLE & start=1: latch a_in, b_in, mode; busy<=1; go to S1_OP. IDLE & start=0: stay; done<=0.
  - S1_OP: drive adder operands (mode 00: M,M; 01: a,b; 10: a,b with subtract; 11: m,m). Go to S1_CAP.
  - S1_CAP, mode!=00: c_out<=datapath result; neg set per mode; done<=1; busy<=0; go to IDLE.
  - S1_CAP, mode 00: i1<=sum; go to S2_OP.
  - S2_OP: operands a,b, add. Go to S2_CAP. S2_CAP: i2<=sum; go to S3_OP.
  - S3_OP: operands i1,i2, subtract. Go to S3_CAP. S3_CAP: c_out<=difference; neg<=0; done<=1; busy<=0; go to IDLE.
- Latency, counted from the edge accepting start to the edge raising done: 2 cycles (modes 01/10/11), 6 cycles (mode 00).
- Ties (a==b): M=m=a.
- start while busy is ignored; inputs may change freely while busy.
- done drops the cycle after it rises. Back-to-back: start may be high in the done cycle (state IDLE) and is accepted.

Optional Feature:
CLAMP_NEG_EN
- Defined: in mode 10, when borrow=1, c_out<=0 (saturating subtract) and neg<=1.
- Undefined: c_out holds the two's-complement wrap and neg<=borrow.
- Other modes are unaffected either way.

Decomposition:
- Package formula_pkg: state enum (7 encodings, 3 bits), mode constants MODE_ABSDIFF=2'b00, MODE_ADD=2'b01, MODE_SUB=2'b10, MODE_DBLMIN=2'b11.
- Sub-module addsub_ripple #(N): combinational N-bit ripple chain with sub control, outputs result and carry/borrow. Instantiated once with N=W+1 and shared across all steps.

Test Plan (W=5):
- Reset: hold rst=0 for 2 cycles with start=1 -> c_out=0, neg=0, busy=0, done=0; no operation begins.
- Mode 00:
  - a=9, b=3 -> done exactly 6 cycles after the start edge, c_out=6, neg=0.
  - a=3, b=9 -> 6.
  - a=b=31 -> 0 (intermediate 62 does not wrap).
- Mode 01, a=31, b=31 -> c_out=62, done 2 cycles after start.
- Mode 11, a=20, b=7 -> c_out=14.
- Mode 10:
  - a=3, b=9 -> without CLAMP_NEG_EN c_out=58, neg=1; with it c_out=0, neg=1.
  - a=9, b=3 -> c_out=6, neg=0 in both builds.
- Handshake and abort:
  - Pulse start again 2 cycles into a mode 00 run -> ignored; single done, c_out correct.
  - Drive rst=0 at cycle 3 of a run -> IDLE, outputs 0, no done.
  - Next start (mode 01, 1+2) -> c_out=3.
